// File: rtl/ctrl_types_pkg.sv
// Shared types for the put-operation sub-FSM and the parent controller that launches it.
package ctrl_types_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_LOOKUP = 3'd1,
    EVICT       = 3'd2,
    WRITE       = 3'd3,
    DONE        = 3'd4
  } put_substate_e;

  typedef enum logic [1:0] {
    UPSERT      = 2'd0,
    INSERT_ONLY = 2'd1,
    UPDATE_ONLY = 2'd2
  } put_mode_e;

  // TIMEOUT sits just past MISSING, which is why the error code needs three bits.
  typedef enum logic [2:0] {
    NONE    = 3'd0,
    FULL    = 3'd1,
    EXISTS  = 3'd2,
    MISSING = 3'd3,
    TIMEOUT = 3'd4
  } put_err_e;

  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;

endpackage

// File: rtl/first_free_enc.sv
// Priority encoder: one-hot position of the lowest free (zero) slot in an occupancy vector.
module first_free_enc #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic [NUM_ENTRIES-1:0] i_used,
  output logic [NUM_ENTRIES-1:0] o_onehot,
  output logic                   o_any_free
);

  localparam logic [NUM_ENTRIES-1:0] ONE_LSB = {{(NUM_ENTRIES-1){1'b0}}, 1'b1};

  logic [NUM_ENTRIES-1:0] w_carry;

  // Adding one ripples through the low run of ones and sets exactly the lowest zero.
  assign w_carry    = i_used + ONE_LSB;
  assign o_onehot   = w_carry & ~i_used;
  assign o_any_free = ~&i_used;

endmodule

// File: rtl/upsert_evict_fsm.sv
// Put-operation sub-FSM: upsert / insert-only / update-only into a one-hot indexed cache.
// Define UPSERT_EVICT_EN to evict a round-robin victim when a miss finds every slot used.
module upsert_evict_fsm
  import ctrl_types_pkg::*;
#(
  parameter int NUM_ENTRIES    = 16,
  parameter int LOOKUP_TIMEOUT = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_enter,
  input  put_mode_e              i_mode,
  input  logic                   i_hit_valid,
  input  logic                   i_hit,
  input  logic [NUM_ENTRIES-1:0] i_used,
  input  logic [NUM_ENTRIES-1:0] i_idx_in,
  output logic                   o_select_out,
  output logic                   o_write_out,
  output logic                   o_evict_out,
  output logic [NUM_ENTRIES-1:0] o_idx_out,
  output logic                   o_rdy_out,
  output logic                   o_op_succ,
  output put_err_e               o_err_code,
  output sub_cmd_t               o_cmd
);

  localparam int               CNT_W    = $clog2(LOOKUP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOOKUP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  put_substate_e          r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_ENTRIES-1:0] r_idx;
  put_err_e               r_err;
  put_mode_e              r_mode;
`ifdef UPSERT_EVICT_EN
  logic [NUM_ENTRIES-1:0] r_victim;
`endif

  logic [NUM_ENTRIES-1:0] w_free_idx;
  logic                   w_any_free;

  first_free_enc #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_first_free_enc (
    .i_used    (i_used),
    .o_onehot  (w_free_idx),
    .o_any_free(w_any_free)
  );

  // enter restarts from any state and ignores en; everything else advances only with en.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_err    <= NONE;
      r_mode   <= UPSERT;
`ifdef UPSERT_EVICT_EN
      r_victim <= {{(NUM_ENTRIES-1){1'b0}}, 1'b1};
`endif
    end else if (i_enter) begin
      r_state <= WAIT_LOOKUP;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_err   <= NONE;
      r_mode  <= i_mode;
    end else if (i_en) begin
      case (r_state)
        WAIT_LOOKUP: begin
          if (i_hit_valid) begin
            if (i_hit) begin
              if (r_mode == INSERT_ONLY) begin
                r_err   <= EXISTS;
                r_state <= DONE;
              end else begin
                r_idx   <= i_idx_in;
                r_state <= WRITE;
              end
            end else if (r_mode == UPDATE_ONLY) begin
              r_err   <= MISSING;
              r_state <= DONE;
            end else if (w_any_free) begin
              r_idx   <= w_free_idx;
              r_state <= WRITE;
            end else begin
`ifdef UPSERT_EVICT_EN
              r_idx   <= r_victim;
              r_state <= EVICT;
`else
              r_err   <= FULL;
              r_state <= DONE;
`endif
            end
          end else if (r_cnt == CNT_LAST) begin
            r_err   <= TIMEOUT;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
`ifdef UPSERT_EVICT_EN
        EVICT: begin
          r_victim <= {r_victim[NUM_ENTRIES-2:0], r_victim[NUM_ENTRIES-1]};
          r_state  <= WRITE;
        end
`endif
        WRITE:   r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes and status decode purely from registered state, so they never glitch on inputs.
  always_comb begin
    o_select_out = 1'b0;
    o_write_out  = 1'b0;
    o_evict_out  = 1'b0;
    o_idx_out    = '0;
    o_rdy_out    = 1'b0;
    o_op_succ    = 1'b0;
    o_err_code   = NONE;
    o_cmd        = '0;
    case (r_state)
`ifdef UPSERT_EVICT_EN
      EVICT: begin
        o_evict_out = 1'b1;
        o_idx_out   = r_idx;
      end
`endif
      WRITE: begin
        o_write_out  = 1'b1;
        o_select_out = 1'b1;
        o_idx_out    = r_idx;
      end
      DONE: begin
        o_cmd.done = 1'b1;
        if (r_err == NONE) begin
          o_rdy_out = 1'b1;
          o_op_succ = 1'b1;
        end else begin
          o_cmd.error = 1'b1;
          o_err_code  = r_err;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_upsert_evict_fsm.sv
// Testbench for upsert_evict_fsm: per-operation expected output sequences checked every cycle.
// Follows UPSERT_EVICT_EN the same way the design does.
module tb_upsert_evict_fsm;
  import ctrl_types_pkg::*;

  localparam int N   = 16;
  localparam int TMO = 8;

  typedef struct packed {
    logic         sel;
    logic         wr;
    logic         ev;
    logic [N-1:0] idx;
    logic         rdy;
    logic         succ;
    logic [2:0]   err;
    logic         done;
    logic         error;
  } outv_t;

  logic         clk;
  logic         rst;
  logic         en;
  logic         enter;
  put_mode_e    mode;
  logic         hitValid;
  logic         hit;
  logic [N-1:0] used;
  logic [N-1:0] idxIn;
  logic         selectOut;
  logic         writeOut;
  logic         evictOut;
  logic [N-1:0] idxOut;
  logic         rdyOut;
  logic         opSucc;
  put_err_e     errCode;
  sub_cmd_t     cmd;

  outv_t expQ[$];
  string tagQ[$];
  int    nCompared   = 0;
  int    nMismatched = 0;
  int    victimPtr   = 0;

  upsert_evict_fsm #(
    .NUM_ENTRIES   (N),
    .LOOKUP_TIMEOUT(TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_enter     (enter),
    .i_mode      (mode),
    .i_hit_valid (hitValid),
    .i_hit       (hit),
    .i_used      (used),
    .i_idx_in    (idxIn),
    .o_select_out(selectOut),
    .o_write_out (writeOut),
    .o_evict_out (evictOut),
    .o_idx_out   (idxOut),
    .o_rdy_out   (rdyOut),
    .o_op_succ   (opSucc),
    .o_err_code  (errCode),
    .o_cmd       (cmd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic outv_t zeroVec();
    outv_t v = '0;
    return v;
  endfunction

  function automatic outv_t writeVec(input logic [N-1:0] t);
    outv_t v = '0;
    v.sel = 1'b1;
    v.wr  = 1'b1;
    v.idx = t;
    return v;
  endfunction

  function automatic outv_t evictVec(input logic [N-1:0] t);
    outv_t v = '0;
    v.ev  = 1'b1;
    v.idx = t;
    return v;
  endfunction

  function automatic outv_t doneVec(input put_err_e e);
    outv_t v = '0;
    v.done = 1'b1;
    if (e == NONE) begin
      v.rdy  = 1'b1;
      v.succ = 1'b1;
    end else begin
      v.error = 1'b1;
      v.err   = e;
    end
    return v;
  endfunction

  function automatic logic [N-1:0] lowestFree(input logic [N-1:0] u);
    for (int i = 0; i < N; i++) begin
      if (!u[i]) return N'(1) << i;
    end
    return '0;
  endfunction

  task automatic checkOutput(input outv_t exp, input string tag);
    outv_t act;
    act.sel   = selectOut;
    act.wr    = writeOut;
    act.ev    = evictOut;
    act.idx   = idxOut;
    act.rdy   = rdyOut;
    act.succ  = opSucc;
    act.err   = errCode;
    act.done  = cmd.done;
    act.error = cmd.error;
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got sel=%b wr=%b ev=%b idx=%h rdy=%b succ=%b err=%0d done=%b error=%b, expected sel=%b wr=%b ev=%b idx=%h rdy=%b succ=%b err=%0d done=%b error=%b",
               tag, act.sel, act.wr, act.ev, act.idx, act.rdy, act.succ, act.err, act.done, act.error,
               exp.sel, exp.wr, exp.ev, exp.idx, exp.rdy, exp.succ, exp.err, exp.done, exp.error);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front(), tagQ.pop_front());
  end

  // Drive one cycle of inputs and queue what the outputs must show after that edge.
  task automatic applyStimulus(input string tag, input logic r, input logic e, input logic n,
                               input put_mode_e m, input logic hv, input logic h,
                               input logic [N-1:0] u, input logic [N-1:0] ix, input outv_t exp);
    rst      = r;
    enter    = e;
    en       = n;
    mode     = m;
    hitValid = hv;
    hit      = h;
    used     = u;
    idxIn    = ix;
    if (r) victimPtr = 0;
    @(posedge clk);
    #1;
    expQ.push_back(exp);
    tagQ.push_back(tag);
  endtask

  // Whole put operation: decide the outcome from the rules, then queue its cycle-by-cycle outputs.
  task automatic runOp(input string tag, input put_mode_e m, input logic [N-1:0] u, input logic h,
                       input logic [N-1:0] ix, input int hvDelay,
                       input logic [N-1:0] litIdx, input put_err_e litErr);
    logic [N-1:0] tgt;
    put_err_e     err;
    logic         doEvict;
    int           nWait;
    outv_t        exp;
    tgt     = '0;
    err     = NONE;
    doEvict = 1'b0;
    if (hvDelay >= TMO) err = TIMEOUT;
    else if (h) begin
      if (m == INSERT_ONLY) err = EXISTS;
      else tgt = ix;
    end else if (m == UPDATE_ONLY) err = MISSING;
    else if (u != '1) tgt = lowestFree(u);
    else begin
`ifdef UPSERT_EVICT_EN
      doEvict = 1'b1;
      tgt     = N'(1) << victimPtr;
`else
      err = FULL;
`endif
    end
    nCompared++;
    if (tgt !== litIdx || err !== litErr) begin
      nMismatched++;
      $display("[TB] FAIL %s/model: model idx=%h err=%0d, hand-computed idx=%h err=%0d",
               tag, tgt, err, litIdx, litErr);
    end

    applyStimulus({tag, "/enter"}, 1'b0, 1'b1, 1'b1, m, 1'b0, 1'b0, u, '0, zeroVec());
    nWait = (err == TIMEOUT) ? TMO : hvDelay;
    for (int k = 0; k < nWait; k++) begin
      exp = (err == TIMEOUT && k == TMO - 1) ? doneVec(TIMEOUT) : zeroVec();
      applyStimulus({tag, "/wait"}, 1'b0, 1'b0, 1'b1, m, 1'b0, 1'b0, u, '0, exp);
    end
    if (err != TIMEOUT) begin
      if (err != NONE) exp = doneVec(err);
      else if (doEvict) exp = evictVec(tgt);
      else exp = writeVec(tgt);
      applyStimulus({tag, "/decide"}, 1'b0, 1'b0, 1'b1, m, 1'b1, h, u, ix, exp);
      if (err == NONE) begin
        if (doEvict) begin
          applyStimulus({tag, "/write"}, 1'b0, 1'b0, 1'b1, m, 1'b0, 1'b0, u, '0, writeVec(tgt));
          victimPtr = (victimPtr + 1) % N;
        end
        applyStimulus({tag, "/done"}, 1'b0, 1'b0, 1'b1, m, 1'b0, 1'b0, u, '0, doneVec(NONE));
      end
    end
    applyStimulus({tag, "/idle"}, 1'b0, 1'b0, 1'b1, m, 1'b0, 1'b0, u, '0, zeroVec());
  endtask

  initial begin
    // Reset, including reset winning over a simultaneous enter.
    applyStimulus("reset0", 1'b1, 1'b0, 1'b0, UPSERT, 1'b0, 1'b0, '0, '0, zeroVec());
    applyStimulus("reset1", 1'b1, 1'b1, 1'b1, UPSERT, 1'b0, 1'b0, '0, '0, zeroVec());
    applyStimulus("rst_beats_enter_a", 1'b0, 1'b0, 1'b1, UPSERT, 1'b1, 1'b1, '0, 16'h0001, zeroVec());
    applyStimulus("rst_beats_enter_b", 1'b0, 1'b0, 1'b1, UPSERT, 1'b1, 1'b1, '0, 16'h0001, zeroVec());

    runOp("upsert_hit",       UPSERT,      16'h0000, 1'b1, 16'h0010, 0, 16'h0010, NONE);
    runOp("upsert_miss",      UPSERT,      16'hFFF7, 1'b0, 16'h0000, 0, 16'h0008, NONE);
    runOp("insert_miss_slow", INSERT_ONLY, 16'h0000, 1'b0, 16'h0000, 2, 16'h0001, NONE);
    runOp("insert_miss_top",  INSERT_ONLY, 16'h7FFF, 1'b0, 16'h0000, 0, 16'h8000, NONE);
    runOp("update_hit",       UPDATE_ONLY, 16'h00FF, 1'b1, 16'h8000, 3, 16'h8000, NONE);
    runOp("insert_exists",    INSERT_ONLY, 16'h0F0F, 1'b1, 16'h0100, 0, 16'h0000, EXISTS);
    runOp("update_missing",   UPDATE_ONLY, 16'h0000, 1'b0, 16'h0000, 0, 16'h0000, MISSING);
    runOp("timeout",          UPSERT,      16'h0000, 1'b0, 16'h0000, TMO, 16'h0000, TIMEOUT);
    runOp("just_in_time",     UPSERT,      16'h0000, 1'b1, 16'h0004, TMO - 1, 16'h0004, NONE);

`ifdef UPSERT_EVICT_EN
    runOp("full_evict_a", UPSERT, 16'hFFFF, 1'b0, 16'h0000, 0, 16'h0001, NONE);
    runOp("full_evict_b", UPSERT, 16'hFFFF, 1'b0, 16'h0000, 0, 16'h0002, NONE);
    for (int i = 2; i <= N; i++) begin
      runOp($sformatf("evict_wrap%0d", i), INSERT_ONLY, 16'hFFFF, 1'b0, 16'h0000, 0,
            N'(1) << (i % N), NONE);
    end
`else
    runOp("full_a", UPSERT,      16'hFFFF, 1'b0, 16'h0000, 0, 16'h0000, FULL);
    runOp("full_b", INSERT_ONLY, 16'hFFFF, 1'b0, 16'h0000, 0, 16'h0000, FULL);
`endif

    // Restart mid-lookup: the timeout count must start over.
    applyStimulus("abort_wait/enter", 1'b0, 1'b1, 1'b1, UPSERT, 1'b0, 1'b0, '0, '0, zeroVec());
    for (int k = 0; k < 3; k++)
      applyStimulus("abort_wait/wait", 1'b0, 1'b0, 1'b1, UPSERT, 1'b0, 1'b0, '0, '0, zeroVec());
    runOp("abort_wait/restart", UPSERT, 16'h0000, 1'b1, 16'h0004, TMO - 1, 16'h0004, NONE);

    // Restart mid-write: no done pulse for the abandoned operation.
    applyStimulus("abort_write/enter", 1'b0, 1'b1, 1'b1, UPSERT, 1'b0, 1'b0, '0, '0, zeroVec());
    applyStimulus("abort_write/decide", 1'b0, 1'b0, 1'b1, UPSERT, 1'b1, 1'b1, '0, 16'h0002, writeVec(16'h0002));
    applyStimulus("abort_write/reenter", 1'b0, 1'b1, 1'b1, UPSERT, 1'b0, 1'b0, '0, '0, zeroVec());
    applyStimulus("abort_write/wait", 1'b0, 1'b0, 1'b1, UPSERT, 1'b0, 1'b0, '0, '0, zeroVec());
    runOp("abort_write/next", UPDATE_ONLY, 16'h0000, 1'b1, 16'h0020, 0, 16'h0020, NONE);

    // en low freezes lookup decisions and the write state; enter ignores en.
    applyStimulus("en/enter_en0", 1'b0, 1'b1, 1'b0, UPSERT, 1'b0, 1'b0, '0, '0, zeroVec());
    applyStimulus("en/hold_a", 1'b0, 1'b0, 1'b0, UPSERT, 1'b1, 1'b1, '0, 16'h0040, zeroVec());
    applyStimulus("en/hold_b", 1'b0, 1'b0, 1'b0, UPSERT, 1'b1, 1'b1, '0, 16'h0040, zeroVec());
    applyStimulus("en/decide", 1'b0, 1'b0, 1'b1, UPSERT, 1'b1, 1'b1, '0, 16'h0040, writeVec(16'h0040));
    applyStimulus("en/write_hold", 1'b0, 1'b0, 1'b0, UPSERT, 1'b0, 1'b0, '0, '0, writeVec(16'h0040));
    applyStimulus("en/done", 1'b0, 1'b0, 1'b1, UPSERT, 1'b0, 1'b0, '0, '0, doneVec(NONE));
    applyStimulus("en/idle", 1'b0, 1'b0, 1'b1, UPSERT, 1'b0, 1'b0, '0, '0, zeroVec());

    // Reset mid-write clears everything, including the eviction pointer.
    applyStimulus("rst_write/enter", 1'b0, 1'b1, 1'b1, UPSERT, 1'b0, 1'b0, '0, '0, zeroVec());
    applyStimulus("rst_write/decide", 1'b0, 1'b0, 1'b1, UPSERT, 1'b1, 1'b1, '0, 16'h0100, writeVec(16'h0100));
    applyStimulus("rst_write/rst", 1'b1, 1'b0, 1'b1, UPSERT, 1'b0, 1'b0, '0, '0, zeroVec());
    applyStimulus("rst_write/after_a", 1'b0, 1'b0, 1'b1, UPSERT, 1'b0, 1'b0, '0, '0, zeroVec());
    applyStimulus("rst_write/after_b", 1'b0, 1'b0, 1'b1, UPSERT, 1'b0, 1'b0, '0, '0, zeroVec());
`ifdef UPSERT_EVICT_EN
    runOp("evict_after_rst", UPSERT, 16'hFFFF, 1'b0, 16'h0000, 0, 16'h0001, NONE);
`else
    runOp("full_after_rst", UPSERT, 16'hFFFF, 1'b0, 16'h0000, 0, 16'h0000, FULL);
`endif

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
